// File: rtl/exe_wb_return_pipe.sv
// -----------------------------------------------------------------------------
// exe_wb_return_pipe
//
// Back end of the ID interface. Carries decoded control from ID through the
// EX, MEM and WB pipeline registers. Feeds hazard information and the
// register-file write port back to ID. Owns the data-memory req/ack handshake
// in the MEM stage, and freezes IF/ID/EX/MEM while an access is outstanding.
//
// Handshake: mem_req is high whenever the MEM stage holds a load or store.
// mem_we, mem_addr and mem_wdata are valid with it and stay stable until the
// cycle in which mem_ack is high. That cycle completes the transfer, and for a
// load mem_rdata is valid in the same cycle. An ack in the first request cycle
// completes with no stall. An ack while mem_req is low is ignored.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   id_*                decoded instruction from ID (id_valid qualifies it)
//   hazard_detected     insert a bubble into EX (overridden by stall)
//   alu_result          ALU result for the instruction currently in EX
//   mem_ack, mem_rdata  data-memory completion and load data
//   dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM
//                       hazard feedback, taken straight from EX/MEM registers
//   mem_req, mem_we, mem_addr, mem_wdata
//                       data-memory request, from the MEM register
//   stall               combinational freeze: memory op pending and not acked
//   writeEn, dest, writeVal
//                       register-file write port, from the WB register
//   stall_cycles        saturating count of stalled edges since reset
//   fsm_state           debug view of the handshake FSM (1 = waiting for ack)
// -----------------------------------------------------------------------------
module exe_wb_return_pipe #(
  parameter int ADDR_LEN      = 4,
  parameter int DATA_LEN      = 16,
  parameter int STALL_CNT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     hazard_detected,
  input  logic [ADDR_LEN-1:0]      id_dest,
  input  logic                     id_WB_EN,
  input  logic                     id_MEM_R_EN,
  input  logic                     id_MEM_W_EN,
  input  logic [DATA_LEN-1:0]      id_val2,
  input  logic [DATA_LEN-1:0]      alu_result,
  input  logic                     mem_ack,
  input  logic [DATA_LEN-1:0]      mem_rdata,
  output logic [ADDR_LEN-1:0]      dest_EXE,
  output logic                     WB_EN_EXE,
  output logic                     MEM_R_EN_EXE,
  output logic [ADDR_LEN-1:0]      dest_MEM,
  output logic                     WB_EN_MEM,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_LEN-1:0]      mem_addr,
  output logic [DATA_LEN-1:0]      mem_wdata,
  output logic                     stall,
  output logic                     writeEn,
  output logic [ADDR_LEN-1:0]      dest,
  output logic [DATA_LEN-1:0]      writeVal,
  output logic [STALL_CNT_LEN-1:0] stall_cycles,
  output logic                     fsm_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state;

  // EX stage register
  logic [ADDR_LEN-1:0] ex_dest;
  logic                ex_wb_en;
  logic                ex_mem_r_en;
  logic                ex_mem_w_en;
  logic [DATA_LEN-1:0] ex_val2;

  // MEM stage register
  logic [ADDR_LEN-1:0] mem_dest;
  logic                mem_wb_en;
  logic                mem_r_en;
  logic                mem_w_en;
  logic [DATA_LEN-1:0] mem_result;
  logic [DATA_LEN-1:0] mem_store;

  // WB stage register
  logic                wb_en;
  logic [ADDR_LEN-1:0] wb_dest;
  logic [DATA_LEN-1:0] wb_val;

  logic [STALL_CNT_LEN-1:0] stall_cnt;

  logic mem_op;
  logic stall_i;

  // Combinational stall so a zero-wait ack costs no cycle.
  assign mem_op  = mem_r_en | mem_w_en;
  assign stall_i = mem_op & ~mem_ack;

  // ---------------------------------------------------------------------------
  // EX register: holds under stall. Stall takes priority over hazard, so a
  // held instruction is never replaced by a bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dest     <= '0;
      ex_wb_en    <= 1'b0;
      ex_mem_r_en <= 1'b0;
      ex_mem_w_en <= 1'b0;
      ex_val2     <= '0;
    end else if (!stall_i) begin
      if (hazard_detected || !id_valid) begin
        ex_dest     <= '0;
        ex_wb_en    <= 1'b0;
        ex_mem_r_en <= 1'b0;
        ex_mem_w_en <= 1'b0;
        ex_val2     <= '0;
      end else begin
        ex_dest     <= id_dest;
        ex_wb_en    <= id_WB_EN;
        ex_mem_r_en <= id_MEM_R_EN;
        ex_mem_w_en <= id_MEM_W_EN;
        ex_val2     <= id_val2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MEM register: holds under stall so the request stays stable until ack.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_dest   <= '0;
      mem_wb_en  <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_result <= '0;
      mem_store  <= '0;
    end else if (!stall_i) begin
      mem_dest   <= ex_dest;
      mem_wb_en  <= ex_wb_en;
      mem_r_en   <= ex_mem_r_en;
      mem_w_en   <= ex_mem_w_en;
      mem_result <= alu_result;
      mem_store  <= ex_val2;
    end
  end

  // ---------------------------------------------------------------------------
  // WB register: a stalled MEM stage hands over a bubble, so the register
  // file sees exactly one write per instruction however long the wait.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_dest <= '0;
      wb_val  <= '0;
    end else if (stall_i) begin
      wb_en   <= 1'b0;
      wb_dest <= '0;
      wb_val  <= '0;
    end else begin
      wb_en   <= mem_wb_en;
      wb_dest <= mem_dest;
      wb_val  <= mem_r_en ? mem_rdata : mem_result;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM. No timeout: an ack is the only way out of WAIT. Reset
  // returns to IDLE and the cleared MEM register drops mem_req, so a late ack
  // has nothing to complete.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (mem_op && !mem_ack) state <= S_WAIT;
        S_WAIT:  if (mem_ack)            state <= S_IDLE;
        default:                         state <= S_IDLE;
      endcase
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_i && (stall_cnt != {STALL_CNT_LEN{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_LEN-1){1'b0}}, 1'b1};
    end
  end

  assign dest_EXE     = ex_dest;
  assign WB_EN_EXE    = ex_wb_en;
  assign MEM_R_EN_EXE = ex_mem_r_en;
  assign dest_MEM     = mem_dest;
  assign WB_EN_MEM    = mem_wb_en;

  assign mem_req   = mem_op;
  assign mem_we    = mem_w_en;
  assign mem_addr  = mem_result;
  assign mem_wdata = mem_store;
  assign stall     = stall_i;

  assign writeEn  = wb_en;
  assign dest     = wb_dest;
  assign writeVal = wb_val;

  assign stall_cycles = stall_cnt;
  assign fsm_state    = (state == S_WAIT);

endmodule
